// File: rtl/pg_mem_arbiter.sv
// pg_mem_arbiter: sequences UART program-upgrade sessions and muxes IMem/DMem write ports between CPU and loader
module pg_mem_arbiter #(
  parameter int unsigned QUIESCE_CYC = 4,
  parameter int unsigned RESTART_CYC = 8,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        upg_wen,
  input  logic [14:0] upg_adr,
  input  logic [31:0] upg_dat,
  input  logic        upg_done,
  input  logic        cpu_mem_we,
  input  logic [13:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  output logic        imem_we,
  output logic [13:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        dmem_we,
  output logic [13:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        cpu_stall,
  output logic        cpu_rst,
  output logic        pg_busy,
  output logic        pg_err,
  output logic [15:0] word_cnt
);
  typedef enum logic [2:0] {RUN, QUIESCE, LOAD, RESTART, ERR} state_e;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        done_armed_q, done_armed_d;
  logic        cpu_stall_q, cpu_rst_q, pg_busy_q, pg_err_q;
  logic        load, pass;
  // next-state: one shared counter serves as phase timer in QUIESCE/RESTART and idle timer in LOAD
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_cnt_d   = word_cnt_q;
    done_armed_d = done_armed_q;
    case (state_q)
      RUN, ERR: if (start_pg) begin
        state_d      = QUIESCE;
        cnt_d        = '0;
        word_cnt_d   = '0;
        done_armed_d = 1'b0;
      end
      QUIESCE: begin
        state_d = (cnt_q == QUIESCE_CYC - 1) ? LOAD : QUIESCE;
        cnt_d   = (cnt_q == QUIESCE_CYC - 1) ? '0 : cnt_q + 32'd1;
      end
      LOAD: begin
        cnt_d        = upg_wen ? '0 : cnt_q + 32'd1;
        word_cnt_d   = (upg_wen && word_cnt_q != 16'hFFFF) ? word_cnt_q + 16'd1 : word_cnt_q;
        done_armed_d = done_armed_q | ~upg_done;
        if (done_armed_q && upg_done) begin
          state_d = RESTART;
          cnt_d   = '0;
        end else if (!upg_wen && cnt_q == TIMEOUT_CYC - 1) state_d = ERR;
      end
      RESTART: begin
        state_d = (cnt_q == RESTART_CYC - 1) ? RUN : RESTART;
        cnt_d   = (cnt_q == RESTART_CYC - 1) ? '0 : cnt_q + 32'd1;
      end
      default: state_d = RUN;
    endcase
  end
  // state, counters and registered status decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      word_cnt_q   <= '0;
      done_armed_q <= 1'b0;
      cpu_stall_q  <= 1'b0;
      cpu_rst_q    <= 1'b0;
      pg_busy_q    <= 1'b0;
      pg_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_cnt_q   <= word_cnt_d;
      done_armed_q <= done_armed_d;
      cpu_stall_q  <= state_d != RUN;
      cpu_rst_q    <= state_d == RESTART;
      pg_busy_q    <= state_d == QUIESCE || state_d == LOAD;
      pg_err_q     <= state_d == ERR;
    end
  end
  assign load       = state_q == LOAD;
  assign pass       = state_q == RUN || state_q == QUIESCE;
  assign imem_we    = load & upg_wen & ~upg_adr[14];
  assign imem_addr  = upg_adr[13:0];
  assign imem_wdata = upg_dat;
  assign dmem_we    = load ? upg_wen & upg_adr[14] : pass & cpu_mem_we;
  assign dmem_addr  = load ? upg_adr[13:0] : cpu_mem_addr;
  assign dmem_wdata = load ? upg_dat : cpu_mem_wdata;
  assign cpu_stall  = cpu_stall_q;
  assign cpu_rst    = cpu_rst_q;
  assign pg_busy    = pg_busy_q;
  assign pg_err     = pg_err_q;
  assign word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_pg_mem_arbiter.sv
// tb_pg_mem_arbiter: directed table-driven bench for pg_mem_arbiter
module tb_pg_mem_arbiter;
  logic        clk = 0, rst = 1;
  logic        start_pg = 0, upg_wen = 0, upg_done = 0, cpu_mem_we = 0;
  logic [14:0] upg_adr = 0;
  logic [31:0] upg_dat = 0, cpu_mem_wdata = 0;
  logic [13:0] cpu_mem_addr = 0;
  logic        imem_we, dmem_we, cpu_stall, cpu_rst, pg_busy, pg_err;
  logic [13:0] imem_addr, dmem_addr;
  logic [31:0] imem_wdata, dmem_wdata;
  logic [15:0] word_cnt;
  int n_chk = 0, n_fail = 0;

  pg_mem_arbiter #(.QUIESCE_CYC(4), .RESTART_CYC(8), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg), .upg_wen(upg_wen), .upg_adr(upg_adr),
    .upg_dat(upg_dat), .upg_done(upg_done), .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .cpu_stall(cpu_stall),
    .cpu_rst(cpu_rst), .pg_busy(pg_busy), .pg_err(pg_err), .word_cnt(word_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic s, w; logic [14:0] adr; logic [31:0] dat; logic d, cwe; logic [13:0] caddr; logic [31:0] cdat;
    logic iwe, dwe; logic [13:0] eaddr; logic [31:0] edat; logic stall, crst, busy, err; logic [15:0] wc;
  } vec_t;
  vec_t tbl[$];

  task automatic v(input logic s, w, input logic [14:0] adr, input logic [31:0] dat, input logic d, cwe,
                   input logic [13:0] caddr, input logic [31:0] cdat, input logic iwe, dwe,
                   input logic [13:0] eaddr, input logic [31:0] edat, input logic stall, crst, busy, err,
                   input logic [15:0] wc);
    vec_t t;
    t.s = s; t.w = w; t.adr = adr; t.dat = dat; t.d = d; t.cwe = cwe; t.caddr = caddr; t.cdat = cdat;
    t.iwe = iwe; t.dwe = dwe; t.eaddr = eaddr; t.edat = edat;
    t.stall = stall; t.crst = crst; t.busy = busy; t.err = err; t.wc = wc;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start_pg = 0; upg_wen = 0; upg_adr = 0; upg_dat = 0; upg_done = 0;
    cpu_mem_we = 0; cpu_mem_addr = 0; cpu_mem_wdata = 0;
  endtask

  initial begin
    int n;
    // s w adr dat d | cwe caddr cdat | iwe dwe eaddr edat | stall crst busy err wc
    v(0,0,15'h0,0,0, 1,14'h10,32'hDEADBEEF, 0,1,14'h10,32'hDEADBEEF, 0,0,0,0,0);
    v(1,0,15'h0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0);
    v(0,0,15'h0,0,0, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,0, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,0, 1,14'h20,32'h12345678, 0,1,14'h20,32'h12345678, 1,0,1,0,0);
    v(0,0,15'h0,0,0, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,1,15'h0000,32'hA0,0, 0,0,0, 1,0,14'h0,32'hA0, 1,0,1,0,0);
    v(0,1,15'h0001,32'hA1,0, 0,0,0, 1,0,14'h1,32'hA1, 1,0,1,0,1);
    v(0,1,15'h0002,32'hA2,0, 0,0,0, 1,0,14'h2,32'hA2, 1,0,1,0,2);
    v(0,1,15'h0003,32'hA3,0, 0,0,0, 1,0,14'h3,32'hA3, 1,0,1,0,3);
    v(0,1,15'h4000,32'hD0,0, 0,0,0, 0,1,14'h0,32'hD0, 1,0,1,0,4);
    v(0,1,15'h4001,32'hD1,1, 0,0,0, 0,1,14'h1,32'hD1, 1,0,1,0,5);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,6);
    v(1,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,6);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,6);
    v(0,0,15'h0,0,1, 1,14'h5,32'h55, 0,0,0,0, 1,1,0,0,6);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,6);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,6);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,6);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,6);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 0,0,0,0,6);
    v(1,0,15'h0,0,1, 0,0,0, 0,0,0,0, 0,0,0,0,6);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(1,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,0, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,0,1,0,0);
    v(0,0,15'h0,0,1, 0,0,0, 0,0,0,0, 1,1,0,0,0);

    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("rst_stall", cpu_stall, 0); chk("rst_crst", cpu_rst, 0); chk("rst_busy", pg_busy, 0);
    chk("rst_err", pg_err, 0); chk("rst_wc", word_cnt, 0); chk("rst_iwe", imem_we, 0);

    foreach (tbl[i]) begin
      start_pg = tbl[i].s; upg_wen = tbl[i].w; upg_adr = tbl[i].adr; upg_dat = tbl[i].dat;
      upg_done = tbl[i].d; cpu_mem_we = tbl[i].cwe; cpu_mem_addr = tbl[i].caddr; cpu_mem_wdata = tbl[i].cdat;
      #1;
      chk($sformatf("v%0d_imem_we", i), imem_we, tbl[i].iwe);
      chk($sformatf("v%0d_dmem_we", i), dmem_we, tbl[i].dwe);
      if (tbl[i].iwe) begin
        chk($sformatf("v%0d_imem_addr", i), imem_addr, tbl[i].eaddr);
        chk($sformatf("v%0d_imem_wdata", i), imem_wdata, tbl[i].edat);
      end
      if (tbl[i].dwe) begin
        chk($sformatf("v%0d_dmem_addr", i), dmem_addr, tbl[i].eaddr);
        chk($sformatf("v%0d_dmem_wdata", i), dmem_wdata, tbl[i].edat);
      end
      chk($sformatf("v%0d_stall", i), cpu_stall, tbl[i].stall);
      chk($sformatf("v%0d_cpu_rst", i), cpu_rst, tbl[i].crst);
      chk($sformatf("v%0d_busy", i), pg_busy, tbl[i].busy);
      chk($sformatf("v%0d_err", i), pg_err, tbl[i].err);
      chk($sformatf("v%0d_word_cnt", i), word_cnt, tbl[i].wc);
      tick();
    end

    // timeout: two words then 100 idle LOAD cycles -> ERR on edge 1+4+2+100
    idle(); rst = 1; tick(); rst = 0;
    start_pg = 1; tick(); start_pg = 0; n = 1;
    repeat (4) begin tick(); n++; end
    upg_wen = 1; upg_adr = 15'h4005; tick(); n++;
    upg_adr = 15'h0006; tick(); n++;
    upg_wen = 0;
    while (!pg_err && n < 300) begin tick(); n++; end
    chk("to_edges", n, 107);
    cpu_mem_we = 1; cpu_mem_addr = 14'h7; #1;
    chk("to_err", pg_err, 1); chk("to_stall", cpu_stall, 1); chk("to_busy", pg_busy, 0);
    chk("to_wc", word_cnt, 2); chk("to_dmem_we", dmem_we, 0);
    tick();
    chk("to_err_hold", pg_err, 1);
    cpu_mem_we = 0; start_pg = 1; tick(); start_pg = 0;
    chk("err_restart_err", pg_err, 0); chk("err_restart_wc", word_cnt, 0);
    chk("err_restart_busy", pg_busy, 1); chk("err_restart_stall", cpu_stall, 1);

    // reset mid-LOAD after three words
    idle(); rst = 1; tick(); rst = 0;
    start_pg = 1; tick(); start_pg = 0;
    repeat (4) tick();
    upg_wen = 1;
    for (int k = 0; k < 3; k++) begin upg_adr = 15'(k); upg_dat = 32'(k); tick(); end
    chk("mid_wc_before", word_cnt, 3);
    upg_adr = 15'h0003; rst = 1; tick(); rst = 0; #1;
    chk("mid_stall", cpu_stall, 0); chk("mid_busy", pg_busy, 0); chk("mid_wc", word_cnt, 0);
    chk("mid_imem_we", imem_we, 0); chk("mid_dmem_we", dmem_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pg_mem_arbiter.md
Name: pg_mem_arbiter

Overview:
- Sequences program-upgrade (UART boot-loader) sessions and arbitrates the instruction and data memory write ports between the running CPU and the UART loader.
- On a start request it stalls the CPU and lets in-flight CPU stores drain. It then routes loader writes to IMem or DMem by address bit 14, and releases the CPU through a restart pulse when the loader reports done.
- Sits between uart_bmpg_0, IFetch/DMem and the CPU clock-enable/reset logic.

Parameters:
- QUIESCE_CYC, 4: cycles the CPU is stalled before the loader takes the memory ports.
- RESTART_CYC, 8: cycles cpu_rst is held high before returning to RUN.
- TIMEOUT_CYC, 50_000_000: idle cycles in LOAD, counting from the last write, before an error is declared. The counter is 32 bits wide.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start_pg  in  1  single-cycle debounced upgrade request
- upg_wen  in  1  loader write strobe, one word per asserted cycle
- upg_adr  in  15  loader word address; bit 14 = 1 selects DMem, bit 14 = 0 selects IMem
- upg_dat  in  32  loader write data
- upg_done  in  1  loader finished (level)
- cpu_mem_we  in  1  CPU store enable
- cpu_mem_addr  in  14  CPU word address
- cpu_mem_wdata  in  32  CPU store data
- imem_we  out  1  IMem write enable
- imem_addr  out  14  IMem write address
- imem_wdata  out  32  IMem write data
- dmem_we  out  1  DMem write enable
- dmem_addr  out  14  DMem address
- dmem_wdata  out  32  DMem write data
- cpu_stall  out  1  CPU clock-enable hold
- cpu_rst  out  1  CPU/PC restart
- pg_busy  out  1  upgrade session active
- pg_err  out  1  loader timeout flag
- word_cnt  out  16  words accepted in the current or last session

Behaviour:
- States:
  - RUN: reset state.
  - QUIESCE: counter runs 0..QUIESCE_CYC-1.
  - LOAD
  - RESTART: counter runs 0..RESTART_CYC-1.
  - ERR
- Reset values: state = RUN, all counters = 0, cpu_stall = 0, cpu_rst = 0, pg_busy = 0, pg_err = 0, word_cnt = 0, done_armed = 0.
- Transitions:
  - RUN -> QUIESCE on start_pg.
  - QUIESCE -> LOAD after QUIESCE_CYC cycles.
  - LOAD -> RESTART when done_armed & upg_done.
  - LOAD -> ERR when the idle counter reaches TIMEOUT_CYC-1 with no upg_wen.
  - RESTART -> RUN after RESTART_CYC cycles.
  - ERR -> QUIESCE on start_pg.
- start_pg is ignored in QUIESCE, LOAD and RESTART.
- Entering QUIESCE clears word_cnt, pg_err, the idle counter and done_armed.
- done_armed is set in LOAD the first cycle upg_done is sampled low. A stale high done from a previous session therefore cannot end a new session.
- Idle counter: cleared on every accepted upg_wen, otherwise increments in LOAD.
- Outputs are registered decodes of state:
  - cpu_stall = 1 in every state except RUN.
  - pg_busy = 1 in QUIESCE and LOAD.
  - cpu_rst = 1 only in RESTART.
  - pg_err = 1 in ERR, and stays 1 until the next session is entered.
- Write path: combinational mux, with the select taken from the state register (zero added latency).
  - LOAD: imem_we = upg_wen & ~upg_adr[14]; dmem_we = upg_wen & upg_adr[14]; both addr = upg_adr[13:0]; both wdata = upg_dat.
  - RUN and QUIESCE: dmem_* = cpu_mem_*, so in-flight stores complete; imem_we = 0.
  - RESTART and ERR: imem_we = 0, dmem_we = 0. CPU stores are dropped.
- word_cnt increments on each upg_wen accepted in LOAD and saturates at 0xFFFF.
- upg_wen arriving in the same cycle as the done-triggered exit is still written and counted.
- rst mid-session: immediate return to RUN; any partial image is left in memory as written.

Test Plan:
- Reset, then RUN with cpu_mem_we = 1, addr = 0x0010, data = 0xDEADBEEF -> dmem_we = 1, dmem_addr = 0x0010, cpu_stall = 0, imem_we = 0.
- start_pg pulse, then 4 loader words at adr 0x0000..0x0003, then 2 words at adr 0x4000..0x4001, then upg_done -> expect:
  - cpu_stall rises 1 cycle after start_pg.
  - 4 imem writes at addr 0..3, then 2 dmem writes at addr 0..1.
  - word_cnt = 6.
  - cpu_rst high for exactly 8 cycles, then RUN.
- upg_done held high from the previous session when start_pg is pulsed -> session stays in LOAD until done goes low then high again; no premature restart.
- LOAD with no upg_wen for TIMEOUT_CYC cycles (override to 100) -> ERR, pg_err = 1, cpu_stall = 1. A following start_pg -> QUIESCE, pg_err = 0, word_cnt = 0.
- CPU store during QUIESCE cycle 2 -> still reaches dmem. CPU store during RESTART -> dmem_we = 0.
- rst asserted mid-LOAD after 3 words -> next cycle: state RUN, cpu_stall = 0, all write enables 0, word_cnt = 0.
